// File: rtl/div_unit.sv
// div_unit: iterative 32-bit signed/unsigned divider (DIV/DIVU).
// One restoring shift-subtract step per cycle. A start accepted at edge E0
// runs 32 steps on E1..E32 and registers the sign-corrected results at E33.
// busy is high from after E0 through E33, and done pulses for the cycle after E33.
//
// Handshake: a start (op_div or op_divu) is accepted only at a rising edge
// where the unit is idle and abort is low. busy is high for the whole
// operation. done is a single-cycle pulse that marks quotient/remainder as
// newly valid, and it is never high together with busy. abort cancels an
// operation in flight without a done pulse. fsm_state exposes the controller
// state for observation.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        start;
    logic        is_signed;
    logic [31:0] dvd_raw;    // operands as issued, kept for sign and zero-divisor fixup
    logic [31:0] dvs_raw;
    logic [31:0] dvs_mag;
    logic [31:0] acc_q;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] acc_r;      // partial remainder
    logic [5:0]  count;

    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] dvd_mag_in;
    logic [31:0] dvs_mag_in;

    // abort takes priority over a start that arrives in the same cycle
    assign start     = (state == IDLE) && (op_div || op_divu) && !abort;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // Controller state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: 32 steps in BUSY, one fixup cycle in FINISH
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = BUSY;
            end
            BUSY: begin
                if (abort)              state_nxt = IDLE;
                else if (count == 6'd31) state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes at start; op_div wins when both start strobes are high
    always_comb begin
        dvd_mag_in = dividend;
        dvs_mag_in = divisor;
        if (op_div && dividend[31]) dvd_mag_in = -dividend;
        if (op_div && divisor[31])  dvs_mag_in = -divisor;
    end

    // One restoring shift-subtract step. When the subtraction succeeds the true
    // difference is below the divisor, so the low 32 bits hold it exactly.
    always_comb begin
        shifted = {acc_r, acc_q[31]};
        ge      = (shifted >= {1'b0, dvs_mag});
        diff    = shifted[31:0] - dvs_mag;
        rem_nxt = ge ? diff : shifted[31:0];
        quo_nxt = {acc_q[30:0], ge};
    end

    // Sign correction (truncate toward zero) and the divide-by-zero result
    always_comb begin
        q_neg = is_signed && (dvd_raw[31] ^ dvs_raw[31]);
        r_neg = is_signed && dvd_raw[31];
        q_fin = q_neg ? -acc_q : acc_q;
        r_fin = r_neg ? -acc_r : acc_r;
        if (dvs_raw == 32'd0) begin
            q_fin = 32'hFFFF_FFFF;
            r_fin = dvd_raw;
        end
    end

    // Datapath: latch operands on start, iterate in BUSY, publish results in FINISH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_signed <= 1'b0;
            dvd_raw   <= 32'd0;
            dvs_raw   <= 32'd0;
            dvs_mag   <= 32'd0;
            acc_q     <= 32'd0;
            acc_r     <= 32'd0;
            count     <= 6'd0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_signed <= op_div;
                        dvd_raw   <= dividend;
                        dvs_raw   <= divisor;
                        dvs_mag   <= dvs_mag_in;
                        acc_q     <= dvd_mag_in;
                        acc_r     <= 32'd0;
                        count     <= 6'd0;
                    end
                end
                BUSY: begin
                    if (!abort) begin
                        acc_q <= quo_nxt;
                        acc_r <= rem_nxt;
                        count <= count + 6'd1;
                    end
                end
                FINISH: begin
                    if (!abort) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
